spart: RTL

SPART -- requirements
Module: spart

---
 rtl/spart.sv | 332 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spart.sv
// SPART: bus-mapped UART with a programmable 16x baud generator and single-byte TX/RX buffers.
// Define SPART_PARITY_EN to add an even-parity bit to both directions (11-bit frames).

module spart (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    localparam logic [15:0] DIV_RESET = 16'h0145;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef SPART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef SPART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       wr_en, rd_en;
    logic       wr_buf, wr_dbl, wr_dbh;
    logic       rd_buf, rd_status;
    logic [7:0] wr_data, rd_data;
    logic [7:0] dbl, dbh;
    logic [7:0] rx_buf;
    logic       frame_err, overrun, parity_err;

    assign wr_en     = iocs & ~iorw;
    assign rd_en     = iocs &  iorw;
    assign wr_buf    = wr_en && (ioaddr == 2'b00);
    assign wr_dbl    = wr_en && (ioaddr == 2'b10);
    assign wr_dbh    = wr_en && (ioaddr == 2'b11);
    assign rd_buf    = rd_en && (ioaddr == 2'b00);
    assign rd_status = rd_en && (ioaddr == 2'b01);
    assign wr_data   = databus;

    always_comb begin
        case (ioaddr)
            2'b00:   rd_data = rx_buf;
            2'b01:   rd_data = {3'b000, parity_err, overrun, frame_err, rda, tbr};
            2'b10:   rd_data = dbl;
            default: rd_data = dbh;
        endcase
    end

    assign databus = rd_en ? rd_data : 8'hzz;

    // ------------------------------------------------------------------
    // Baud generator: tick when the counter hits zero, then reload
    // ------------------------------------------------------------------
    logic [15:0] baud_cnt;
    logic        tick;

    assign tick = (baud_cnt == 16'h0000);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbl      <= DIV_RESET[7:0];
            dbh      <= DIV_RESET[15:8];
            baud_cnt <= DIV_RESET;
        end else if (wr_dbl) begin
            dbl      <= wr_data;
            baud_cnt <= {dbh, wr_data};
        end else if (wr_dbh) begin
            dbh      <= wr_data;
            baud_cnt <= {wr_data, dbl};
        end else if (tick) begin
            baud_cnt <= {dbh, dbl};
        end else begin
            baud_cnt <= baud_cnt - 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t  tx_state, tx_state_nxt;
    logic [7:0] tx_buf, tx_shift;
    logic       tx_full;
    logic [3:0] tx_tick_cnt;
    logic [2:0] tx_bit_cnt;
    logic       tx_load, tx_shift_en, tx_bit_end;
`ifdef SPART_PARITY_EN
    logic       tx_par;
`endif

    assign tbr        = ~tx_full;
    assign tx_bit_end = tick && (tx_tick_cnt == 4'hF);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_load      = 1'b0;
        tx_shift_en  = 1'b0;
        txd          = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (tx_full) begin
                    tx_load      = 1'b1;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (tx_bit_end) tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                txd = tx_shift[0];
                if (tx_bit_end) begin
                    tx_shift_en = 1'b1;
                    if (tx_bit_cnt == 3'd7) begin
`ifdef SPART_PARITY_EN
                        tx_state_nxt = TX_PARITY;
`else
                        tx_state_nxt = TX_STOP;
`endif
                    end
                end
            end
`ifdef SPART_PARITY_EN
            TX_PARITY: begin
                txd = tx_par;
                if (tx_bit_end) tx_state_nxt = TX_STOP;
            end
`endif
            TX_STOP: begin
                // A waiting byte starts immediately, with no idle bit between frames.
                if (tx_bit_end) begin
                    if (tx_full) begin
                        tx_load      = 1'b1;
                        tx_state_nxt = TX_START;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= TX_IDLE;
        else      tx_state <= tx_state_nxt;
    end

    // NOTE: the data registers get a reset too, so nothing reads X after a reset abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_buf      <= 8'h00;
            tx_full     <= 1'b0;
            tx_shift    <= 8'h00;
            tx_tick_cnt <= 4'h0;
            tx_bit_cnt  <= 3'd0;
`ifdef SPART_PARITY_EN
            tx_par      <= 1'b0;
`endif
        end else begin
            if (tx_load) begin
                tx_shift   <= tx_buf;
                tx_full    <= 1'b0;
                tx_bit_cnt <= 3'd0;
`ifdef SPART_PARITY_EN
                tx_par     <= ^tx_buf;
`endif
            end else begin
                // A write while the buffer is still full is dropped.
                if (wr_buf && !tx_full) begin
                    tx_buf  <= wr_data;
                    tx_full <= 1'b1;
                end
                if (tx_shift_en) begin
                    tx_shift   <= {1'b0, tx_shift[7:1]};
                    tx_bit_cnt <= tx_bit_cnt + 3'd1;
                end
            end
            if (tx_state == TX_IDLE) tx_tick_cnt <= 4'h0;
            else if (tick)           tx_tick_cnt <= tx_tick_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t  rx_state, rx_state_nxt;
    logic [2:0] rx_sync;
    logic       rx_bit, rx_fall;
    logic [7:0] rx_shift;
    logic [3:0] rx_tick_cnt;
    logic [2:0] rx_bit_cnt;
    logic       rx_half, rx_bit_end, rx_restart, rx_sample, rx_done;
    logic       rx_par_ok;
`ifdef SPART_PARITY_EN
    logic       rx_par_bit, rx_par_cap;
`endif

    // rx_sync[1:0] is the synchronizer; rx_sync[2] is history for edge detection.
    assign rx_bit     = rx_sync[1];
    assign rx_fall    = rx_sync[2] & ~rx_sync[1];
    assign rx_half    = tick && (rx_tick_cnt == 4'h7);
    assign rx_bit_end = tick && (rx_tick_cnt == 4'hF);

    always_comb begin
        rx_state_nxt = rx_state;
        rx_restart   = 1'b0;
        rx_sample    = 1'b0;
        rx_done      = 1'b0;
`ifdef SPART_PARITY_EN
        rx_par_cap   = 1'b0;
`endif
        case (rx_state)
            RX_IDLE: if (rx_fall) rx_state_nxt = RX_START;
            RX_START: begin
                // Mid-bit check: a line already back high was only a glitch.
                if (rx_half) begin
                    rx_restart   = 1'b1;
                    rx_state_nxt = rx_bit ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_sample = 1'b1;
                    if (rx_bit_cnt == 3'd7) begin
`ifdef SPART_PARITY_EN
                        rx_state_nxt = RX_PARITY;
`else
                        rx_state_nxt = RX_STOP;
`endif
                    end
                end
            end
`ifdef SPART_PARITY_EN
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_par_cap   = 1'b1;
                    rx_state_nxt = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_done      = 1'b1;
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= RX_IDLE;
        else      rx_state <= rx_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync     <= 3'b111;
            rx_shift    <= 8'h00;
            rx_tick_cnt <= 4'h0;
            rx_bit_cnt  <= 3'd0;
`ifdef SPART_PARITY_EN
            rx_par_bit  <= 1'b0;
`endif
        end else begin
            rx_sync <= {rx_sync[1:0], rxd};
            if (rx_state == RX_IDLE || rx_restart) rx_tick_cnt <= 4'h0;
            else if (tick)                         rx_tick_cnt <= rx_tick_cnt + 4'd1;
            if (rx_state == RX_IDLE) rx_bit_cnt <= 3'd0;
            else if (rx_sample)      rx_bit_cnt <= rx_bit_cnt + 3'd1;
            if (rx_sample) rx_shift <= {rx_bit, rx_shift[7:1]};
`ifdef SPART_PARITY_EN
            if (rx_par_cap) rx_par_bit <= rx_bit;
`endif
        end
    end

`ifdef SPART_PARITY_EN
    assign rx_par_ok = (rx_par_bit == ^rx_shift);
`else
    assign rx_par_ok = 1'b1;
`endif

    // Delivery and sticky flags: a completing byte wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_buf     <= 8'h00;
            rda        <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (rx_done) begin
                rx_buf <= rx_shift;
                rda    <= 1'b1;
            end else if (rd_buf) begin
                rda <= 1'b0;
            end

            if (rx_done && rda && !rd_buf) overrun <= 1'b1;
            else if (rd_status)            overrun <= 1'b0;

            if (rx_done && !rx_bit) frame_err <= 1'b1;
            else if (rd_status)     frame_err <= 1'b0;

            if (rx_done && !rx_par_ok) parity_err <= 1'b1;
            else if (rd_status)        parity_err <= 1'b0;
        end
    end

endmodule
